// File: rtl/grid_sram_ctrl_if.sv
// Port bundle for grid_sram_ctrl: read port, masked write port and fill control.
interface grid_sram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  fill_start;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  ready;
  logic                  busy;
  logic                  fill_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, fill_start, fill_value,
    input  rd_data, rd_valid, ready, busy, fill_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask, fill_start, fill_value,
    output rd_data, rd_valid, ready, busy, fill_done
  );
endinterface

// File: rtl/grid_sram_ctrl.sv
// Grid SRAM for the maze router: one read port, one bit-masked write port,
// read latency 1 or 2, selectable read-during-write result and a fill engine
// that writes every word once per routing pass.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | user read/write/fill_start accepted, ready=1
// FILL  | one word per cycle written with the latched fill value, busy=1
module grid_sram_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int RAM_DEPTH    = 64,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input logic              clk,
  input logic              rst,
  grid_sram_ctrl_if.slave  bus
);

  // Counter has one spare state beyond the last address so the terminal
  // compare can never alias onto a valid word index.
  localparam int                  CNT_W    = $clog2(RAM_DEPTH + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic                  fill_done_q, fill_done_d;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;

  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

  logic                  ready;
  logic                  rd_acc, wr_acc;
  logic                  rd_in_range, wr_in_range;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign ready       = (state_q == IDLE);
  assign rd_acc      = bus.rd_en & ready;
  assign wr_acc      = bus.wr_en & ready;
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign fill_addr   = ADDR_WIDTH'(cnt_q);

  // Masked merge of the new data into the currently stored word.
  always_comb begin
    wr_merged = '0;
    if (wr_in_range) begin
      wr_merged = (mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
    end
  end

  // Read word selection, including same-address bypass when RDW_MODE=1.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (RDW_MODE == 1 && wr_acc && wr_in_range && bus.wr_addr == bus.rd_addr) begin
        rd_word = wr_merged;
      end else begin
        rd_word = mem[bus.rd_addr];
      end
    end
  end

  // Storage array; not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= fill_val_q;
    end else if (wr_acc && wr_in_range) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  // Read pipeline: one or two register stages from accepted rd_en to rd_valid.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  p_valid;
      logic [DATA_WIDTH-1:0] p_data;

      // Two-stage read: capture at acceptance, present one cycle later.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_valid    <= 1'b0;
          p_data     <= '0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          p_valid    <= rd_acc;
          if (rd_acc) p_data <= rd_word;
          rd_valid_q <= p_valid;
          if (p_valid) rd_data_q <= p_data;
        end
      end
    end else begin : g_lat1
      // Single-stage read: present at the edge after acceptance.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= rd_word;
        end
      end
    end
  endgenerate

  // Fill FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Fill FSM next state: latch value on start, walk every address once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_val_d  = fill_val_q;
    fill_done_d = 1'b0;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          state_d    = FILL;
          cnt_d      = '0;
          fill_val_d = bus.fill_value;
        end
      end
      FILL: begin
        fill_we = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = ready;
  assign bus.busy      = ~ready;
  assign bus.fill_done = fill_done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_grid_sram_ctrl.sv
// Directed bench: two instances share one stimulus.
//   a: depth 64, latency 1, old-data read-during-write
//   b: depth 48, latency 2, new-data read-during-write
module tb_grid_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic [5:0] rd_addr = '0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] wr_mask = '0;
  logic       fill_start = 1'b0;
  logic [7:0] fill_value = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  grid_sram_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus_a ();
  grid_sram_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus_b ();

  assign bus_a.rd_en = rd_en;           assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr;       assign bus_b.rd_addr = rd_addr;
  assign bus_a.wr_en = wr_en;           assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr;       assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;       assign bus_b.wr_data = wr_data;
  assign bus_a.wr_mask = wr_mask;       assign bus_b.wr_mask = wr_mask;
  assign bus_a.fill_start = fill_start; assign bus_b.fill_start = fill_start;
  assign bus_a.fill_value = fill_value; assign bus_b.fill_value = fill_value;

  grid_sram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RAM_DEPTH(64),
                   .READ_LATENCY(1), .RDW_MODE(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  grid_sram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RAM_DEPTH(48),
                   .READ_LATENCY(2), .RDW_MODE(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single write, starting and ending on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Read, optionally with a same-cycle write; checks both latencies.
  task automatic rd_chk(input string tag, input logic [5:0] a,
                        input logic [7:0] exp_a, input logic [7:0] exp_b,
                        input bit with_wr, input logic [7:0] wd);
    rd_en = 1'b1; rd_addr = a;
    if (with_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = wd; wr_mask = 8'hFF;
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    check({tag, "_va1"}, 32'(bus_a.rd_valid), 32'd1);
    check({tag, "_da1"}, 32'(bus_a.rd_data), 32'(exp_a));
    check({tag, "_vb1"}, 32'(bus_b.rd_valid), 32'd0);
    @(negedge clk);
    check({tag, "_va2"}, 32'(bus_a.rd_valid), 32'd0);
    check({tag, "_vb2"}, 32'(bus_b.rd_valid), 32'd1);
    check({tag, "_db2"}, 32'(bus_b.rd_data), 32'(exp_b));
  endtask

  // Fill with a fixed 70-cycle observation window.
  task automatic run_fill(input string tag, input logic [7:0] val, input bit inject,
                          input bit rd_same, input logic [5:0] ra, input logic [7:0] rexp);
    int busy_a = 0, busy_b = 0, done_a = 0, done_b = 0, rdy_a = 0;
    int didx_a = -1, didx_b = -1, rv_a = 0, rv_b = 0;
    logic [7:0] rdat_a = '0, rdat_b = '0;
    fill_start = 1'b1; fill_value = val;
    if (rd_same) begin rd_en = 1'b1; rd_addr = ra; end
    @(negedge clk);
    fill_start = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 70; i++) begin
      busy_a += int'(bus_a.busy);
      busy_b += int'(bus_b.busy);
      rdy_a  += int'(bus_a.ready);
      if (bus_a.fill_done) begin done_a++; didx_a = i; end
      if (bus_b.fill_done) begin done_b++; didx_b = i; end
      if (bus_a.rd_valid) begin rv_a++; rdat_a = bus_a.rd_data; end
      if (bus_b.rd_valid) begin rv_b++; rdat_b = bus_b.rd_data; end
      if (inject && i == 10) begin
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 8'hFF; wr_mask = 8'hFF;
        rd_en = 1'b1; rd_addr = 6'd10;
        fill_start = 1'b1; fill_value = 8'h55;
      end else begin
        wr_en = 1'b0; rd_en = 1'b0; fill_start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_a"}, 32'(busy_a), 32'd64);
    check({tag, "_busy_b"}, 32'(busy_b), 32'd48);
    check({tag, "_ready_a"}, 32'(rdy_a), 32'd6);
    check({tag, "_done_a"}, 32'(done_a), 32'd1);
    check({tag, "_done_b"}, 32'(done_b), 32'd1);
    check({tag, "_didx_a"}, 32'(didx_a), 32'd64);
    check({tag, "_didx_b"}, 32'(didx_b), 32'd48);
    check({tag, "_rv_a"}, 32'(rv_a), rd_same ? 32'd1 : 32'd0);
    check({tag, "_rv_b"}, 32'(rv_b), rd_same ? 32'd1 : 32'd0);
    if (rd_same) begin
      check({tag, "_rd_a"}, 32'(rdat_a), 32'(rexp));
      check({tag, "_rd_b"}, 32'(rdat_b), 32'(rexp));
    end
  endtask

  initial begin
    int done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_a", 32'(bus_a.rd_valid), 32'd0);
    check("rst_data_a", 32'(bus_a.rd_data), 32'd0);
    check("rst_busy_a", 32'(bus_a.busy), 32'd0);
    check("rst_ready_a", 32'(bus_a.ready), 32'd1);
    check("rst_done_a", 32'(bus_a.fill_done), 32'd0);
    check("rst_valid_b", 32'(bus_b.rd_valid), 32'd0);
    check("rst_busy_b", 32'(bus_b.busy), 32'd0);

    // Clear fill and spot reads.
    run_fill("fill00", 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    rd_chk("r0", 6'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    rd_chk("r37", 6'd37, 8'h00, 8'h00, 1'b0, 8'h00);
    rd_chk("r63", 6'd63, 8'h00, 8'h00, 1'b0, 8'h00);

    // Masked writes.
    wr(6'd5, 8'hA5, 8'hFF);
    wr(6'd5, 8'h0F, 8'h0F);
    rd_chk("mask", 6'd5, 8'hAF, 8'hAF, 1'b0, 8'h00);
    wr(6'd5, 8'h33, 8'h00);
    rd_chk("mask0", 6'd5, 8'hAF, 8'hAF, 1'b0, 8'h00);

    // Read during write to the same address.
    wr(6'd9, 8'h11, 8'hFF);
    rd_chk("rdw", 6'd9, 8'h11, 8'h22, 1'b1, 8'h22);
    rd_chk("rdw_after", 6'd9, 8'h22, 8'h22, 1'b0, 8'h00);

    // Back-to-back reads.
    wr(6'd1, 8'h01, 8'hFF);
    wr(6'd2, 8'h02, 8'hFF);
    wr(6'd3, 8'h03, 8'hFF);
    rd_en = 1'b1; rd_addr = 6'd1;
    @(negedge clk);
    check("b2b_va0", 32'(bus_a.rd_valid), 32'd1);
    check("b2b_da0", 32'(bus_a.rd_data), 32'h01);
    check("b2b_vb0", 32'(bus_b.rd_valid), 32'd0);
    rd_addr = 6'd2;
    @(negedge clk);
    check("b2b_da1", 32'(bus_a.rd_data), 32'h02);
    check("b2b_vb1", 32'(bus_b.rd_valid), 32'd1);
    check("b2b_db1", 32'(bus_b.rd_data), 32'h01);
    rd_addr = 6'd3;
    @(negedge clk);
    rd_en = 1'b0;
    check("b2b_da2", 32'(bus_a.rd_data), 32'h03);
    check("b2b_vb2", 32'(bus_b.rd_valid), 32'd1);
    check("b2b_db2", 32'(bus_b.rd_data), 32'h02);
    @(negedge clk);
    check("b2b_va3", 32'(bus_a.rd_valid), 32'd0);
    check("b2b_hold_a", 32'(bus_a.rd_data), 32'h03);
    check("b2b_vb3", 32'(bus_b.rd_valid), 32'd1);
    check("b2b_db3", 32'(bus_b.rd_data), 32'h03);
    @(negedge clk);
    check("b2b_vb4", 32'(bus_b.rd_valid), 32'd0);
    check("b2b_hold_b", 32'(bus_b.rd_data), 32'h03);

    // Address 50 is in range for a, out of range for b.
    wr(6'd50, 8'h5A, 8'hFF);
    rd_chk("oor", 6'd50, 8'h5A, 8'h00, 1'b0, 8'h00);

    // Fill with a same-cycle read of addr 5 and blocked user traffic mid-fill.
    run_fill("fill3c", 8'h3C, 1'b1, 1'b1, 6'd5, 8'hAF);
    rd_chk("f3c_a10", 6'd10, 8'h3C, 8'h3C, 1'b0, 8'h00);
    rd_chk("f3c_a20", 6'd20, 8'h3C, 8'h3C, 1'b0, 8'h00);

    // Reset 20 cycles into a fill of 8'h77 over zeroed contents.
    run_fill("fill00b", 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    fill_start = 1'b1; fill_value = 8'h77;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy_a", 32'(bus_a.busy), 32'd0);
    check("abort_busy_b", 32'(bus_b.busy), 32'd0);
    check("abort_valid_a", 32'(bus_a.rd_valid), 32'd0);
    check("abort_valid_b", 32'(bus_b.rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      done_cnt += int'(bus_a.fill_done) + int'(bus_b.fill_done);
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    rd_chk("ab_a0", 6'd0, 8'h77, 8'h77, 1'b0, 8'h00);
    rd_chk("ab_a19", 6'd19, 8'h77, 8'h77, 1'b0, 8'h00);
    rd_chk("ab_a20", 6'd20, 8'h00, 8'h00, 1'b0, 8'h00);
    rd_chk("ab_a40", 6'd40, 8'h00, 8'h00, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grid_sram_ctrl.md
Name: grid_sram_ctrl

Overview:
Parametrised successor to the team's single-port synchronous grid SRAM for the maze router. It provides one independent read port and one write port, with a per-bit write mask and a selectable read latency of 1 or 2 cycles. A configurable read-during-write policy decides what a same-address read returns. A hardware fill engine clears or initialises the whole grid in RAM_DEPTH cycles before each routing pass, so the router no longer relies on a file preload.

Parameters:
DATA_WIDTH, 8, bits per grid cell word
ADDR_WIDTH, 6, address bits
RAM_DEPTH, 64, number of words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted rd_en to rd_valid; legal values are 1 and 2
RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns the newly merged data

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  asynchronous, active-high reset
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data, registered
rd_valid  out  1  one-cycle pulse, rd_data valid
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH  per-bit write enable; 1 = write this bit
fill_start  in  1  start a full-array fill
fill_value  in  DATA_WIDTH  fill word, sampled together with fill_start
ready  out  1  equals !busy; user ports are accepted only while high
busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse when the fill completes

Behaviour:
- Reset (async assert, sync release): rd_data=0, rd_valid=0, busy=0, fill_done=0, fill counter=0, FSM=IDLE, read pipeline flushed.
  - Memory contents are NOT reset.
  - Reset during a fill aborts it; the array is left partially filled and no fill_done pulse is produced.
- Acceptance: rd_en, wr_en and fill_start are acted on only when ready=1. While busy=1 they are dropped silently: no memory change, no rd_valid.
- Write: on an accepted wr_en, mem[wr_addr] <= (mem & ~wr_mask) | (wr_data & wr_mask). An all-zero mask makes the write a no-op.
- Read: an accepted rd_en at edge N sets rd_valid=1 and rd_data=word at edge N+READ_LATENCY.
  - rd_valid is high only in that cycle.
  - rd_data holds its last value otherwise.
  - Back-to-back reads give one result per cycle.
- Read during write, same cycle and same address:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged post-write word.
  - Different addresses: fully independent.
- Out of range (address >= RAM_DEPTH): the write is ignored; the read returns 0 with rd_valid still pulsed.
- Fill FSM has two states, IDLE and FILL.
  - IDLE -> FILL on fill_start with ready=1. fill_value is latched, counter=0, busy=1 from the next edge.
  - User rd/wr accepted in the same cycle as fill_start are executed normally.
  - In FILL: each cycle write the full word mem[counter]=fill_value, ignoring wr_mask, then counter+1.
  - After the write to RAM_DEPTH-1: FILL -> IDLE, busy=0, fill_done=1 for one cycle.
  - Total: busy is high for exactly RAM_DEPTH cycles.
  - A read accepted before the fill (READ_LATENCY=2, in flight) completes normally during FILL with its pre-fill data.
  - fill_start while busy has no effect.
- The counter is sized ceil(log2(RAM_DEPTH+1)) so the terminal count does not alias.

Test Plan:
- Reset, then fill_start with fill_value=8'h00 -> busy high for 64 cycles, fill_done pulses once on the cycle busy falls. Reads of addr 0, 37 and 63 return 8'h00 with rd_valid after READ_LATENCY.
- Write addr 5 = 8'hA5 with mask 8'hFF, then write 8'h0F with mask 8'h0F -> read addr 5 returns 8'hAF. A write with mask 8'h00 leaves the word unchanged.
- Same-cycle read and write to addr 9 (old 8'h11, new 8'h22, mask 8'hFF) -> RDW_MODE=0 returns 8'h11, RDW_MODE=1 returns 8'h22. The next read returns 8'h22 in both modes.
- READ_LATENCY=2, back-to-back reads of addr 1, 2, 3 holding 8'h01, 8'h02, 8'h03 -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first rd_en, with data in order.
- During a fill of 8'h3C, drive wr_en to addr 10 = 8'hFF and rd_en -> the write is ignored and there is no rd_valid. After fill_done, addr 10 reads 8'h3C. A second fill_start mid-fill is ignored, so busy totals 64 cycles.
- Assert rst at fill cycle 20 with fill value 8'h77 over prior contents 8'h00 -> busy=0 and rd_valid=0 immediately, with no fill_done pulse. Addresses 0..19 read 8'h77; address 40 reads 8'h00.
